// File: rtl/regwrite_pkg.sv
// Shared defaults and requester identifiers for the register-file writeback arbiter.
package regwrite_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic {
    ID_ALU  = REQ_ALU,
    ID_LOAD = REQ_LOAD
  } req_id_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue claims,
// cleared by writeback transfers, queried combinationally by issue.
module reg_scoreboard
  import regwrite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic              clr_reg_busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // NOTE: start from the current value so every path assigns busy_d and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_reg] = 1'b0;
    // Applied after the clear so a same-edge claim of the same register wins.
    if (set_valid) busy_d[set_reg] = 1'b1;
  end

  // NOTE: the busy array is a bank of flops, not a RAM, so it can and must be reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // The rw term covers the cycle between the transfer edge and the file write.
  assign busy1 = busy_q[chk_reg1] | (wr_valid && (wr_reg == chk_reg1));
  assign busy2 = busy_q[chk_reg2] | (wr_valid && (wr_reg == chk_reg2));

  assign clr_reg_busy = busy_q[clr_reg];

endmodule

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter between the ALU and load writeback paths, with registered
// register-file write port, pending-write scoreboard and contention counter.
module regwrite_arbiter
  import regwrite_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic              rw,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] datawritten,
  output logic [15:0]       conflict_cnt,
  output logic              wr_unclaimed
);

  req_id_e           last_grant;
  req_id_e           grant_id;
  logic              xfer;
  logic              contention;
  logic [ADDR_W-1:0] grant_reg;
  logic [DATA_W-1:0] grant_data;
  logic              grant_reg_busy;

  assign contention = req0_valid & req1_valid;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (contention) begin
      if (last_grant == ID_LOAD) req0_ready = 1'b1;
      else                       req1_ready = 1'b1;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign grant_id   = req1_ready ? ID_LOAD : ID_ALU;
  assign grant_reg  = req1_ready ? req1_reg  : req0_reg;
  assign grant_data = req1_ready ? req1_data : req0_data;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= ID_LOAD;
      rw           <= 1'b0;
      writereg     <= '0;
      datawritten  <= '0;
      conflict_cnt <= '0;
      wr_unclaimed <= 1'b0;
    end else begin
      rw <= xfer;
      if (xfer) begin
        writereg    <= grant_reg;
        datawritten <= grant_data;
        last_grant  <= grant_id;
        if (!grant_reg_busy) wr_unclaimed <= 1'b1;
      end
      if (contention && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_valid    (claim_valid),
    .set_reg      (claim_reg),
    .clr_valid    (xfer),
    .clr_reg      (grant_reg),
    .wr_valid     (rw),
    .wr_reg       (writereg),
    .chk_reg1     (chk_reg1),
    .chk_reg2     (chk_reg2),
    .busy1        (busy1),
    .busy2        (busy2),
    .clr_reg_busy (grant_reg_busy)
  );

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter; register-file writes are checked against a queue of expected writes.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, claim_valid;
  logic [4:0]  req0_reg, req1_reg, claim_reg, chk_reg1, chk_reg2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, busy1, busy2, rw, wr_unclaimed;
  logic [4:0]  writereg;
  logic [31:0] datawritten;
  logic [15:0] conflict_cnt;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  regwrite_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .claim_valid  (claim_valid),
    .claim_reg    (claim_reg),
    .chk_reg1     (chk_reg1),
    .chk_reg2     (chk_reg2),
    .busy1        (busy1),
    .busy2        (busy2),
    .rw           (rw),
    .writereg     (writereg),
    .datawritten  (datawritten),
    .conflict_cnt (conflict_cnt),
    .wr_unclaimed (wr_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.r = r;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic idle_inputs();
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    claim_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Every register-file write is matched against the oldest expected write.
  always @(negedge clk) begin
    if (!reset && rw) begin
      if (exp_q.size() == 0) begin
        check("rw_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_reg", {27'd0, writereg}, {27'd0, w.r});
        check("wr_data", datawritten, w.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0_reg = '0; req1_reg = '0; claim_reg = '0;
    req0_data = '0; req1_data = '0;
    chk_reg1 = 5'd1; chk_reg2 = 5'd2;

    // Reset state
    repeat (3) tick();
    check("rst_rw", {31'd0, rw}, 32'd0);
    check("rst_writereg", {27'd0, writereg}, 32'd0);
    check("rst_data", datawritten, 32'd0);
    check("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    check("rst_unclaimed", {31'd0, wr_unclaimed}, 32'd0);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    reset = 1'b0;
    tick();

    // Single requester: one-cycle rw pulse
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'h20;
    #1;
    check("single_ready0", {31'd0, req0_ready}, 32'd1);
    check("single_ready1", {31'd0, req1_ready}, 32'd0);
    push(5'd5, 32'h20);
    tick();
    req0_valid = 1'b0;
    check("single_rw", {31'd0, rw}, 32'd1);
    check("single_reg", {27'd0, writereg}, 32'd5);
    check("single_data", datawritten, 32'h20);
    tick();
    check("single_rw_off", {31'd0, rw}, 32'd0);
    check("single_hold_reg", {27'd0, writereg}, 32'd5);
    check("single_hold_data", datawritten, 32'h20);

    // Contention: alternating grants starting with requester 0 after reset
    do_reset();
    claim_valid = 1'b1; claim_reg = 5'd3; tick();
    claim_reg = 5'd9; tick();
    claim_valid = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3;
    req1_valid = 1'b1; req1_reg = 5'd9;
    for (int i = 0; i < 4; i++) begin
      logic g0;
      g0 = (i % 2 == 0);
      req0_data = 32'hA0 + i;
      req1_data = 32'hB0 + i;
      #1;
      check("rr_ready0", {31'd0, req0_ready}, {31'd0, g0});
      check("rr_ready1", {31'd0, req1_ready}, {31'd0, !g0});
      if (g0) push(5'd3, 32'hA0 + i);
      else    push(5'd9, 32'hB0 + i);
      // Re-claim the granted register so later writes to it stay claimed
      claim_valid = 1'b1;
      claim_reg   = g0 ? 5'd3 : 5'd9;
      tick();
    end
    idle_inputs();
    check("rr_cnt", {16'd0, conflict_cnt}, 32'd4);
    tick();
    check("rr_unclaimed", {31'd0, wr_unclaimed}, 32'd0);

    // Claim then write reg 7: busy through the rw cycle, clear after
    claim_valid = 1'b1; claim_reg = 5'd7; tick();
    claim_valid = 1'b0;
    chk_reg1 = 5'd7;
    #1;
    check("claim7_busy", {31'd0, busy1}, 32'd1);
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h7777;
    #1;
    check("w7_ready1", {31'd0, req1_ready}, 32'd1);
    push(5'd7, 32'h7777);
    tick();
    req1_valid = 1'b0;
    check("w7_busy_rw", {31'd0, busy1}, 32'd1);
    tick();
    check("w7_busy_after", {31'd0, busy1}, 32'd0);
    check("w7_unclaimed", {31'd0, wr_unclaimed}, 32'd0);

    // Same-edge claim and write of reg 4: set wins
    claim_valid = 1'b1; claim_reg = 5'd4; tick();
    req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h4444;
    push(5'd4, 32'h4444);
    tick();
    idle_inputs();
    chk_reg2 = 5'd4;
    tick();
    check("same_edge_busy", {31'd0, busy2}, 32'd1);
    check("same_edge_unclaimed", {31'd0, wr_unclaimed}, 32'd0);

    // Unclaimed write to reg 12: sticky error, data still written
    chk_reg1 = 5'd12;
    #1;
    check("r12_idle_busy", {31'd0, busy1}, 32'd0);
    req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 32'hC0FFEE;
    push(5'd12, 32'hC0FFEE);
    tick();
    req0_valid = 1'b0;
    check("r12_unclaimed", {31'd0, wr_unclaimed}, 32'd1);
    check("r12_data", datawritten, 32'hC0FFEE);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r12_sticky", {31'd0, wr_unclaimed}, 32'd1);
    end

    // Reset during the rw cycle discards the in-flight write
    check("pre_rst_cnt", {16'd0, conflict_cnt}, 32'd4);
    req0_valid = 1'b1; req0_reg = 5'd2; req0_data = 32'h2222;
    claim_valid = 1'b1; claim_reg = 5'd6;
    push(5'd2, 32'h2222);
    tick();
    idle_inputs();
    check("mid_rw", {31'd0, rw}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    chk_reg1 = 5'd3; chk_reg2 = 5'd4;
    #1;
    check("mid_rst_rw", {31'd0, rw}, 32'd0);
    check("mid_rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    check("mid_rst_busy3", {31'd0, busy1}, 32'd0);
    check("mid_rst_busy4", {31'd0, busy2}, 32'd0);
    check("mid_rst_unclaimed", {31'd0, wr_unclaimed}, 32'd0);
    chk_reg1 = 5'd6; chk_reg2 = 5'd9;
    #1;
    check("mid_rst_busy6", {31'd0, busy1}, 32'd0);
    check("mid_rst_busy9", {31'd0, busy2}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("post_rst_rw", {31'd0, rw}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
